// File: rtl/exe_arbiter_pkg.sv
// Shared definitions for the exe arbiter slice.
//   exe_arb_state_e : arbiter FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   MaxReq          : largest supported requester count
//   idx_width()     : width of a requester index (at least 1 bit)
package exe_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } exe_arb_state_e;

  localparam int MaxReq = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exe_rr_arbiter.sv
// Combinational round-robin picker for the exe arbiter.
//   req_i   : request vector
//   ptr_i   : index holding top priority; priority runs ptr, ptr+1, ... wrapping
//   lock_i  : when set and owner_i is requesting, owner_i wins regardless of ptr_i
//   owner_i : index of the current lock holder
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   idx_o   : index of the granted requester (0 when nothing requests)
module exe_rr_arbiter
  import exe_arbiter_pkg::*;
#(
  parameter int NumReq = 2,
  localparam int IdxW  = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  input  logic              lock_i,
  input  logic [IdxW-1:0]   owner_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  // One spare bit so ptr + k can exceed NumReq-1 before the wrap.
  logic [IdxW:0] cand;
  logic          found;

  // NOTE: every output and temporary gets a default before any branch, so no
  // path through this block leaves a value unassigned (which would infer a latch).
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    if (lock_i && req_i[owner_i]) begin
      gnt_o[owner_i] = 1'b1;
      idx_o          = owner_i;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        cand = {1'b0, ptr_i} + (IdxW+1)'(k);
        if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
        if (!found && req_i[cand[IdxW-1:0]]) begin
          found                   = 1'b1;
          gnt_o[cand[IdxW-1:0]]   = 1'b1;
          idx_o                   = cand[IdxW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/exe_arbiter.sv
// Shares one combinational exe (ALU) unit between NumReq requesters.
// Round-robin grant in IDLE, operands registered on accept, exe result
// registered in EXEC, result held in RESP until the owner takes it.
// Optional feature macro: EXE_ARB_LOCK_EN -- a requester accepted with its
// req_lock_i bit set keeps priority for the next grant and the rr pointer
// does not advance. Without the macro req_lock_i is ignored.
// Ports:
//   clk_i, rstn_i            : clock, synchronous active-low reset
//   req_valid_i/req_ready_o  : per-requester request handshake
//   req_op1_i/op2_i/ctrl_i   : packed per-requester operands and control
//   req_lock_i               : keep grant for next op (lock build only)
//   rsp_valid_o/rsp_ready_i  : per-requester response handshake
//   rsp_data_o               : shared result bus
//   exe_op1_o/op2_o/ctrl_o   : registered operands to the exe unit
//   exe_out_i                : exe unit result
module exe_arbiter
  import exe_arbiter_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int ExeCtrlWidth = 5,
  parameter int NumReq       = 2
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*DataWidth-1:0]    req_op1_i,
  input  logic [NumReq*DataWidth-1:0]    req_op2_i,
  input  logic [NumReq*ExeCtrlWidth-1:0] req_ctrl_i,
  input  logic [NumReq-1:0]              req_lock_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  input  logic [NumReq-1:0]              rsp_ready_i,
  output logic [DataWidth-1:0]           rsp_data_o,
  output logic [DataWidth-1:0]           exe_op1_o,
  output logic [DataWidth-1:0]           exe_op2_o,
  output logic [ExeCtrlWidth-1:0]        exe_ctrl_o,
  input  logic [DataWidth-1:0]           exe_out_i
);

  localparam int IdxW = idx_width(NumReq);

  if (NumReq < 2 || NumReq > MaxReq) begin : g_bad_numreq
    $error("exe_arbiter: NumReq out of range");
  end

  exe_arb_state_e          state_q, state_d;
  logic [DataWidth-1:0]    op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [ExeCtrlWidth-1:0] ctrl_q, ctrl_d;
  logic [IdxW-1:0]         owner_q, owner_d, ptr_q, ptr_d;
  logic                    lock_q, lock_d;
  logic [NumReq-1:0]       gnt;
  logic [IdxW-1:0]         win_idx, ptr_next;
  logic                    lock_hit;

  exe_rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .lock_i  (lock_q),
    .owner_i (owner_q),
    .gnt_o   (gnt),
    .idx_o   (win_idx)
  );

  assign ptr_next = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;

`ifdef EXE_ARB_LOCK_EN
  assign lock_hit = req_lock_i[win_idx];
`else
  assign lock_hit = 1'b0;
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
`endif

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    ctrl_d      = ctrl_q;
    res_d       = res_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    unique case (state_q)
      IDLE: begin
        // Grant is suppressed while reset is asserted so nothing is accepted.
        if (rstn_i) req_ready_o = gnt;
        if (rstn_i && |req_valid_i) begin
          op1_d   = req_op1_i[win_idx*DataWidth +: DataWidth];
          op2_d   = req_op2_i[win_idx*DataWidth +: DataWidth];
          ctrl_d  = req_ctrl_i[win_idx*ExeCtrlWidth +: ExeCtrlWidth];
          owner_d = win_idx;
          lock_d  = lock_hit;
          // A locked accept leaves the rr pointer where it was.
          if (!lock_hit) ptr_d = ptr_next;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = exe_out_i;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, tested inside the clocked block.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  assign exe_op1_o  = op1_q;
  assign exe_op2_o  = op2_q;
  assign exe_ctrl_o = ctrl_q;
  assign rsp_data_o = res_q;

endmodule

// File: tb/tb_exe_arbiter.sv
// Directed bench for exe_arbiter: a 32-bit two-requester instance for the
// handshake/arbitration scenarios and a 64-bit instance for the wide subtract.
// A small ALU model stands in for the exe unit. Inputs change on the falling
// edge; outputs are checked 1 ns later, away from the rising edge.
module tb_exe_arbiter;

  localparam int DW = 32;
  localparam int CW = 5;
  localparam int NR = 2;

  localparam logic [CW-1:0] CTRL_ADD = 5'd0;
  localparam logic [CW-1:0] CTRL_SUB = 5'd1;
  localparam logic [CW-1:0] CTRL_XOR = 5'd4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // 32-bit instance
  logic [NR-1:0]    req_valid, req_ready, req_lock, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] req_op1, req_op2;
  logic [NR*CW-1:0] req_ctrl;
  logic [DW-1:0]    rsp_data, exe_op1, exe_op2, exe_out;
  logic [CW-1:0]    exe_ctrl;
  logic [63:0]      alu32_full;

  // 64-bit instance
  logic [NR-1:0]    w_valid, w_ready, w_lock, w_rsp_valid, w_rsp_ready;
  logic [NR*64-1:0] w_op1, w_op2;
  logic [NR*CW-1:0] w_ctrl;
  logic [63:0]      w_data, w_exe_op1, w_exe_op2, w_exe_out;
  logic [CW-1:0]    w_exe_ctrl;

  function automatic logic [63:0] alu(input logic [63:0] a, input logic [63:0] b,
                                      input logic [CW-1:0] c);
    case (c)
      CTRL_ADD: return a + b;
      CTRL_SUB: return a - b;
      CTRL_XOR: return a ^ b;
      default:  return '0;
    endcase
  endfunction

  assign alu32_full = alu({32'b0, exe_op1}, {32'b0, exe_op2}, exe_ctrl);
  assign exe_out    = alu32_full[31:0];
  assign w_exe_out  = alu(w_exe_op1, w_exe_op2, w_exe_ctrl);

  exe_arbiter #(.DataWidth(DW), .ExeCtrlWidth(CW), .NumReq(NR)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op1_i(req_op1), .req_op2_i(req_op2), .req_ctrl_i(req_ctrl),
    .req_lock_i(req_lock),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .exe_op1_o(exe_op1), .exe_op2_o(exe_op2), .exe_ctrl_o(exe_ctrl),
    .exe_out_i(exe_out)
  );

  exe_arbiter #(.DataWidth(64), .ExeCtrlWidth(CW), .NumReq(NR)) u_dut64 (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(w_valid), .req_ready_o(w_ready),
    .req_op1_i(w_op1), .req_op2_i(w_op2), .req_ctrl_i(w_ctrl),
    .req_lock_i(w_lock),
    .rsp_valid_o(w_rsp_valid), .rsp_ready_i(w_rsp_ready), .rsp_data_o(w_data),
    .exe_op1_o(w_exe_op1), .exe_op2_o(w_exe_op2), .exe_ctrl_o(w_exe_ctrl),
    .exe_out_i(w_exe_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c);
    req_op1[i*DW +: DW]  = a;
    req_op2[i*DW +: DW]  = b;
    req_ctrl[i*CW +: CW] = c;
  endtask

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  logic [NR-1:0] exp_oh;
  int            exp_own [6];
  logic [DW-1:0] exp_res [NR];

  initial begin
    rstn = 1'b0; req_valid = '0; req_lock = '0; rsp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_ctrl = '0;
    w_valid = '0; w_lock = '0; w_rsp_ready = '0; w_op1 = '0; w_op2 = '0; w_ctrl = '0;

    // ---- 1: reset state, then single ADD from requester 0
    @(negedge clk);
    req_valid = 2'b01;
    set_req(0, 32'd5, 32'd3, CTRL_ADD);
    next_cycle(); #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_exe_op1", exe_op1, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rstn = 1'b1; #1;
    check("t1_ready", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00; #1;
    check("t1_exec_ready", req_ready, 2'b00);
    check("t1_exec_valid", rsp_valid, 2'b00);
    check("t1_exe_op1", exe_op1, 32'd5);
    check("t1_exe_op2", exe_op2, 32'd3);
    check("t1_exe_ctrl", exe_ctrl, CTRL_ADD);
    next_cycle(); #1;
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rsp_data", rsp_data, 32'd8);
    rsp_ready = 2'b01;
    next_cycle(); #1;
    check("t1_back_idle", rsp_valid, 2'b00);
    rsp_ready = 2'b00;

    // ---- 2: both requesters continuously valid, grants alternate 0,1,0,1
    rstn = 1'b0; req_valid = 2'b11;
    set_req(0, 32'd100, 32'd1, CTRL_ADD);
    set_req(1, 32'd50, 32'd8, CTRL_SUB);
    exp_res[0] = 32'd101;
    exp_res[1] = 32'd42;
    next_cycle();
    rstn = 1'b1; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = 2'b01 << (k % 2);
      #1;
      check("t2_grant", req_ready, exp_oh);
      next_cycle(); #1;
      check("t2_exec_ready", req_ready, 2'b00);
      next_cycle(); #1;
      check("t2_rsp_owner", rsp_valid, exp_oh);
      check("t2_rsp_data", rsp_data, exp_res[k % 2]);
      check("t2_resp_ready", req_ready, 2'b00);
      next_cycle();
    end

    // ---- 3: response held 5 cycles; non-owner ready ignored
    rsp_ready = 2'b00; req_valid = 2'b10;
    set_req(1, 32'hA5, 32'h0F, CTRL_XOR);
    #1;
    check("t3_grant", req_ready, 2'b10);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    rsp_ready = 2'b01; req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_hold_valid", rsp_valid, 2'b10);
      check("t3_hold_data", rsp_data, 32'hAA);
      check("t3_hold_ready", req_ready, 2'b00);
      next_cycle();
    end
    rsp_ready = 2'b10;
    next_cycle(); #1;
    rsp_ready = 2'b00;
    check("t3_release_valid", rsp_valid, 2'b00);
    check("t3_release_grant", req_ready, 2'b01);

    // ---- 4: reset during EXEC drops the op and restores requester 0 priority
    req_valid = 2'b01;
    set_req(0, 32'd5, 32'd3, CTRL_ADD);
    #1;
    check("t4_grant", req_ready, 2'b01);
    next_cycle();
    rstn = 1'b0; req_valid = 2'b11; #1;
    check("t4_in_exec", exe_op1, 32'd5);
    next_cycle();
    rstn = 1'b1; #1;
    check("t4_no_rsp", rsp_valid, 2'b00);
    check("t4_regs_clear", exe_op1, 32'd0);
    check("t4_r0_wins", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    next_cycle(); #1;
    check("t4_rsp_owner", rsp_valid, 2'b01);
    check("t4_rsp_data", rsp_data, 32'd8);
    rsp_ready = 2'b01;
    next_cycle();

    // ---- 5: lock request from requester 1 (ignored without the lock build)
`ifdef EXE_ARB_LOCK_EN
    exp_own = '{0, 1, 1, 1, 1, 0};
`else
    exp_own = '{0, 1, 0, 1, 0, 1};
`endif
    rstn = 1'b0; req_valid = 2'b11;
    set_req(0, 32'd100, 32'd1, CTRL_ADD);
    set_req(1, 32'd50, 32'd8, CTRL_SUB);
    next_cycle();
    rstn = 1'b1; rsp_ready = 2'b11; req_lock = 2'b10;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req_lock = 2'b00;
      exp_oh = 2'b01 << exp_own[k];
      #1;
      check("t5_grant", req_ready, exp_oh);
      next_cycle();
      next_cycle(); #1;
      check("t5_rsp_owner", rsp_valid, exp_oh);
      check("t5_rsp_data", rsp_data, exp_res[exp_own[k]]);
      next_cycle();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;

    // ---- 6: 64-bit instance, 0 - 1
    w_valid = 2'b01;
    w_op1[63:0] = 64'd0;
    w_op2[63:0] = 64'd1;
    w_ctrl[CW-1:0] = CTRL_SUB;
    #1;
    check("t6_grant", w_ready, 2'b01);
    next_cycle();
    w_valid = 2'b00;
    next_cycle(); #1;
    check("t6_rsp_valid", w_rsp_valid, 2'b01);
    check("t6_rsp_data", w_data, 64'hFFFF_FFFF_FFFF_FFFF);
    w_rsp_ready = 2'b01;
    next_cycle(); #1;
    check("t6_back_idle", w_rsp_valid, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
